// File: rtl/apb_intc.sv
// APB interrupt controller: per-source level/edge pending, enable mask,
// lowest-index-first active ID and a registered CPU interrupt request.
module apb_intc #(
    parameter int NUM_IRQ = 8
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               PSEL,
    input  logic [7:2]         PADDR,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    input  logic [NUM_IRQ-1:0] IRQIN,
    output logic               IRQOUT
);

    localparam logic [5:0] A_PEND  = 6'h00;
    localparam logic [5:0] A_EN    = 6'h01;
    localparam logic [5:0] A_EDGE  = 6'h02;
    localparam logic [5:0] A_ACT   = 6'h03;
    localparam logic [5:0] A_SWSET = 6'h04;

    logic [NUM_IRQ-1:0] irq_in_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               irqout_q;

    logic               wr_en;
    logic               wr_pend, wr_en_reg, wr_edge, wr_swset;
    logic [NUM_IRQ-1:0] wdata;
    logic               valid;
    logic [4:0]         act_id;
    logic               unused_wdata;

    assign wr_en     = PSEL & ~PENABLE & PWRITE;
    assign wr_pend   = wr_en && (PADDR == A_PEND);
    assign wr_en_reg = wr_en && (PADDR == A_EN);
    assign wr_edge   = wr_en && (PADDR == A_EDGE);
    assign wr_swset  = wr_en && (PADDR == A_SWSET);
    assign wdata     = PWDATA[NUM_IRQ-1:0];

    assign unused_wdata = ^PWDATA[31:NUM_IRQ];

    assign en_d   = wr_en_reg ? wdata : en_q;
    assign edge_d = wr_edge ? wdata : edge_q;

    // Edge sources: a new set event beats a simultaneous W1C.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (edge_q[i]) begin
                if ((IRQIN[i] & ~irq_in_q[i]) | (wr_swset & wdata[i]))
                    pend_d[i] = 1'b1;
                else if (wr_pend & wdata[i])
                    pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = IRQIN[i];
            end
        end
    end

    always_comb begin
        valid  = |(pend_q & en_q);
        act_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i] & en_q[i])
                act_id = 5'(i);
        end
    end

    always_comb begin
        rdata_d = '0;
        case (PADDR)
            A_PEND:  rdata_d = 32'(pend_q);
            A_EN:    rdata_d = 32'(en_q);
            A_EDGE:  rdata_d = 32'(edge_q);
            A_ACT:   rdata_d = {valid, 26'd0, act_id};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_in_q <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            edge_q   <= '0;
            rdata_q  <= '0;
            irqout_q <= 1'b0;
        end else begin
            irq_in_q <= IRQIN;
            pend_q   <= pend_d;
            en_q     <= en_d;
            edge_q   <= edge_d;
            rdata_q  <= rdata_d;
            irqout_q <= |(pend_q & en_q);
        end
    end

    assign PRDATA  = (PSEL & ~PWRITE) ? rdata_q : 32'd0;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign IRQOUT  = irqout_q;

endmodule

// File: tb/tb_apb_intc.sv
// Directed bench for apb_intc: register-map table plus hand-written
// sequences for latency, edge latching, collisions, priority and reset.
module tb_apb_intc;

    logic        clk;
    logic        rst;
    logic        psel;
    logic [5:0]  paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  irqin;
    logic        irqout;

    int checks;
    int failures;

    apb_intc #(.NUM_IRQ(8)) dut (
        .PCLK    (clk),
        .PRESET  (rst),
        .PSEL    (psel),
        .PADDR   (paddr),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .PSLVERR (pslverr),
        .IRQIN   (irqin),
        .IRQOUT  (irqout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = a; pwdata = d;
        tick(1);
        penable = 1'b1;
        tick(1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = a;
        tick(1);
        penable = 1'b1;
        d = prdata;
        tick(1);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [5:0] a,
                            input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        checks = 0;
        failures = 0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; irqin = '0;

        vecs[0]  = '{1'b0, 6'h00, 32'h0, 32'h0, "rst_pending"};
        vecs[1]  = '{1'b0, 6'h01, 32'h0, 32'h0, "rst_enable"};
        vecs[2]  = '{1'b0, 6'h02, 32'h0, 32'h0, "rst_edge"};
        vecs[3]  = '{1'b0, 6'h03, 32'h0, 32'h0, "rst_active"};
        vecs[4]  = '{1'b0, 6'h04, 32'h0, 32'h0, "rst_swset"};
        vecs[5]  = '{1'b1, 6'h01, 32'hA5, 32'h0, "wr_enable"};
        vecs[6]  = '{1'b1, 6'h02, 32'h3C, 32'h0, "wr_edge"};
        vecs[7]  = '{1'b0, 6'h01, 32'h0, 32'hA5, "rb_enable"};
        vecs[8]  = '{1'b0, 6'h02, 32'h0, 32'h3C, "rb_edge"};
        vecs[9]  = '{1'b0, 6'h04, 32'h0, 32'h0, "swset_reads0"};
        vecs[10] = '{1'b0, 6'h05, 32'h0, 32'h0, "unmapped"};
        vecs[11] = '{1'b1, 6'h01, 32'hFFFF_FFFF, 32'h0, "wr_en_all"};
        vecs[12] = '{1'b0, 6'h01, 32'h0, 32'hFF, "en_upper0"};
        vecs[13] = '{1'b1, 6'h01, 32'h01, 32'h0, "wr_en_1"};
        vecs[14] = '{1'b1, 6'h02, 32'h00, 32'h0, "wr_edge_0"};
        vecs[15] = '{1'b0, 6'h00, 32'h0, 32'h0, "pend_idle"};

        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_irqout", {31'd0, irqout}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("pready", {31'd0, pready}, 32'd1);
        check("pslverr", {31'd0, pslverr}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                apb_read(vecs[i].addr, d);
                check(vecs[i].name, d, vecs[i].exp);
            end
        end

        // Level path, ENABLE=0x01 EDGE=0
        irqin = 8'h01;
        tick(1);
        check("lvl_irqout_k", {31'd0, irqout}, 32'd0);
        tick(1);
        check("lvl_irqout_k1", {31'd0, irqout}, 32'd1);
        rd_check("lvl_pend", 6'h00, 32'h01);
        apb_write(6'h00, 32'h01);
        rd_check("lvl_w1c_noeff", 6'h00, 32'h01);
        irqin = 8'h00;
        tick(1);
        check("lvl_fall_k", {31'd0, irqout}, 32'd1);
        tick(1);
        check("lvl_fall_k1", {31'd0, irqout}, 32'd0);
        rd_check("lvl_pend_clr", 6'h00, 32'h00);

        // Edge latch and W1C
        apb_write(6'h02, 32'h01);
        irqin = 8'h01;
        tick(1);
        irqin = 8'h00;
        tick(2);
        check("edg_irqout", {31'd0, irqout}, 32'd1);
        rd_check("edg_latched", 6'h00, 32'h01);
        apb_write(6'h00, 32'h01);
        check("edg_w1c_irqout", {31'd0, irqout}, 32'd0);
        rd_check("edg_w1c_pend", 6'h00, 32'h00);

        // Held high: single pend, no re-pend after clear
        irqin = 8'h01;
        tick(2);
        check("hold_irqout", {31'd0, irqout}, 32'd1);
        apb_write(6'h00, 32'h01);
        tick(3);
        rd_check("hold_no_repend", 6'h00, 32'h00);
        check("hold_irqout0", {31'd0, irqout}, 32'd0);

        // Set/clear collision
        irqin = 8'h00;
        tick(1);
        irqin = 8'h01;
        apb_write(6'h00, 32'h01);
        rd_check("collision", 6'h00, 32'h01);
        irqin = 8'h00;
        tick(1);
        apb_write(6'h00, 32'h01);
        rd_check("coll_clean", 6'h00, 32'h00);

        // SWSET on a level source has no effect
        apb_write(6'h02, 32'h00);
        apb_write(6'h04, 32'h01);
        rd_check("swset_level", 6'h00, 32'h00);

        // Priority and mask
        apb_write(6'h02, 32'hFF);
        apb_write(6'h04, 32'h28);
        apb_write(6'h01, 32'h20);
        rd_check("act_5", 6'h03, 32'h8000_0005);
        check("prio_irqout", {31'd0, irqout}, 32'd1);
        apb_write(6'h01, 32'h08);
        rd_check("act_3", 6'h03, 32'h8000_0003);
        apb_write(6'h01, 32'h00);
        rd_check("act_none", 6'h03, 32'h0);
        check("mask_irqout", {31'd0, irqout}, 32'd0);
        rd_check("pend_masked", 6'h00, 32'h28);

        // Reset mid-transfer
        apb_write(6'h04, 32'hFF);
        apb_write(6'h01, 32'hFF);
        tick(1);
        check("pre_rst_irqout", {31'd0, irqout}, 32'd1);
        rd_check("pre_rst_pend", 6'h00, 32'hFF);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 6'h01; pwdata = 32'h55;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        psel = 1'b0; pwrite = 1'b0;
        check("post_rst_irqout", {31'd0, irqout}, 32'd0);
        check("post_rst_prdata", prdata, 32'd0);
        for (int a = 0; a < 5; a++) begin
            apb_read(6'(a), d);
            check($sformatf("post_rst_reg%0d", a), d, 32'd0);
        end
        check("post_rst_irqout2", {31'd0, irqout}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_intc.md
# apb_intc

APB interrupt controller that sits directly downstream of `apb_timer` and the other APB peripherals. It collects their interrupt outputs, e.g. `TIMERINT`, into a pending register, masks them, and presents one registered interrupt request to the CPU. It also reports the highest-priority active source through a readable ID register. Each source is individually configured as level-sensitive or rising-edge-latched.

## Interface
Parameters:
- `NUM_IRQ`, default 8: number of interrupt sources, legal range 1..31. Source 0 has the highest priority.

Ports:
- `PCLK` input 1: clock. Everything is on its rising edge.
- `PRESET` input 1: reset. One clock; reset is synchronous and active-high.
- `PSEL` input 1: device select.
- `PADDR[7:2]` input 6: word address.
- `PENABLE` input 1: APB access phase.
- `PWRITE` input 1: write control.
- `PWDATA` input 32: write data.
- `PRDATA` output 32: read data.
- `PREADY` output 1: tied 1.
- `PSLVERR` output 1: tied 0.
- `IRQIN` input NUM_IRQ: source interrupts, synchronous to `PCLK`. Bit 0 is typically `TIMERINT`.
- `IRQOUT` output 1: registered interrupt request to the CPU.

## Operation
Register map (unused or unmapped bits read 0):
- 0x00 PENDING, RW1C. Read returns `PendReg`. Writing 1 clears the bit for edge sources only; writes to level-source bits have no effect.
- 0x04 ENABLE, RW. Per-source mask. Reset value 0.
- 0x08 EDGE, RW. Per-source mode: 1 = rising-edge latched, 0 = level. Reset value 0.
- 0x0C ACTIVE, RO.
  - Bit [31] is VALID = |(PENDING & ENABLE).
  - Bits [4:0] hold the lowest index i with PENDING[i] & ENABLE[i]; 0 when VALID = 0.
- 0x10 SWSET, WO, reads 0. Writing 1 sets PENDING for edge sources; no effect on level sources.

APB behaviour:
- Write strobe `WriteEnable = PSEL & ~PENABLE & PWRITE`. Registers update at the end of the setup cycle.
- Read:
  - `ReadMux` is decoded combinationally from `PADDR`.
  - It is registered every cycle into `ReadMuxReg`.
  - `PRDATA = (PSEL & ~PWRITE) ? ReadMuxReg : 0`.
  - Read data therefore reflects register state at the end of the setup cycle.

Pending logic, per bit i, every cycle:
- `IrqInReg <= IRQIN`.
- Level source (EDGE[i] = 0): `PendReg[i] <= IRQIN[i]`.
- Edge source (EDGE[i] = 1):
  - Set term: `IRQIN[i] & ~IrqInReg[i]`, or SWSET write with PWDATA[i] = 1.
  - Clear term: PENDING write with PWDATA[i] = 1.
  - Set has priority over clear in the same cycle.
- Changing EDGE[i] from 1 to 0 makes the bit follow IRQIN from the next cycle. Changing 0 to 1 keeps the current PendReg value latched.
- `IRQOUT <= |(PendReg & ENABLE)`, registered.
- ENABLE only masks. Disabled sources still pend and remain visible in PENDING.

## Timing
- Reset values: all registers 0, `IrqInReg` 0, `ReadMuxReg` 0, `IRQOUT` 0, `PRDATA` 0.
- Latency from source to CPU:
  - `IRQIN[i]` rises before clock edge k, so PENDING[i] = 1 after edge k.
  - `IRQOUT` = 1 after edge k+1, i.e. 2 cycles.
  - The same latency applies in level and edge mode.
- Clearing a level source:
  - `IRQIN` deasserts before edge k, so PENDING clears after edge k.
  - `IRQOUT` falls after edge k+1.
- Clearing an edge source:
  - A W1C in the setup cycle ending at edge k clears PENDING after edge k.
  - `IRQOUT` falls after edge k+1, unless another edge arrived in cycle k.
- Source held high in edge mode: pends only once, on the rising edge. After a W1C it stays clear until IRQIN falls and rises again.
- ENABLE write at edge k: `IRQOUT` reflects the new mask after edge k+1.
- `PRESET` asserted mid-transfer: all state returns to reset values at that edge. Pending edge events and the transfer in progress are lost. `IrqInReg` = 0, so an IRQIN that is high when reset deasserts is detected as a rising edge on the first cycle.
- `PREADY` is always 1. Every transfer completes in 2 cycles (setup + access).

## Test plan
- Reset/readback:
  - After reset, read 0x00, 0x04, 0x08, 0x0C, 0x10; all return 0.
  - Write ENABLE = 0xA5, EDGE = 0x3C; reading back gives 0xA5 and 0x3C.
- Level path:
  - With ENABLE = 0x01, EDGE = 0, drive IRQIN[0] = 1 before edge k.
  - PENDING = 0x01 after edge k, `IRQOUT` = 1 after edge k+1.
  - Deassert IRQIN[0]; `IRQOUT` = 0 two cycles later.
  - W1C 0x01 while IRQIN[0] is high leaves PENDING = 0x01.
- Edge latch and W1C:
  - With EDGE = 0x01, ENABLE = 0x01, pulse IRQIN[0] for 1 cycle; PENDING stays 0x01 after the pulse.
  - W1C 0x01: PENDING = 0 and `IRQOUT` = 0 one cycle later.
  - Holding IRQIN[0] high after the clear causes no re-pend.
- Set/clear collision: W1C 0x01 in the same cycle as a new rising edge on IRQIN[0] leaves PENDING[0] = 1.
- Priority and mask:
  - With EDGE = 0xFF, SWSET 0x28, ENABLE = 0x20: ACTIVE reads 0x8000_0005 and `IRQOUT` = 1.
  - Set ENABLE = 0x08: ACTIVE reads 0x8000_0003.
  - Set ENABLE = 0: ACTIVE reads 0x0000_0000, `IRQOUT` = 0, and PENDING still reads 0x28.
- Reset mid-operation: with PENDING = 0xFF and `IRQOUT` = 1, assert `PRESET` for 1 cycle. All registers read 0 and `IRQOUT` = 0 in the cycle after reset.
